// File: rtl/field_loader.sv
// Field loader: turns an ASCII lumber map ('.', '|', '#', newline) into the flattened
// trees/lumberyards initial-state vectors and pulses load once the last cell lands.
//
// state   | meaning
// --------+------------------------------------------------------------
// COLLECT | parsing cells and line ends, filling the vectors
// DONE    | map complete; bytes still accepted but discarded
// ERROR   | malformed input seen; stalls until clear or rst_n
module field_loader #(
    parameter int WIDTH  = 50,
    parameter int HEIGHT = 50
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic [WIDTH*HEIGHT-1:0]   trees,
    output logic [WIDTH*HEIGHT-1:0]   lumberyards,
    output logic                      load,
    output logic                      done,
    output logic                      error
);

    localparam int NCELL = WIDTH * HEIGHT;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;

    localparam logic [CW-1:0] COL_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    localparam logic [7:0] CH_DOT  = 8'h2E;
    localparam logic [7:0] CH_TREE = 8'h7C;
    localparam logic [7:0] CH_YARD = 8'h23;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DONE    = 2'd1,
        ERROR   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   col, col_nxt;
    logic [RW-1:0]   row, row_nxt;
    logic [IW-1:0]   cell_idx;
    logic            accept;
    logic            is_dot, is_tree, is_yard, is_cell, is_cr, is_lf;
    logic            set_tree, set_yard, set_done, set_err;

    assign in_ready = (state != ERROR);
    assign accept   = in_valid && in_ready;

    assign is_dot  = (in_data == CH_DOT);
    assign is_tree = (in_data == CH_TREE);
    assign is_yard = (in_data == CH_YARD);
    assign is_cell = is_dot || is_tree || is_yard;
    assign is_cr   = (in_data == CH_CR);
    assign is_lf   = (in_data == CH_LF);

    // Only meaningful while col < WIDTH, which is the only time it is used.
    assign cell_idx = IW'(row) * IW'(WIDTH) + IW'(col);

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        row_nxt   = row;
        set_tree  = 1'b0;
        set_yard  = 1'b0;
        set_done  = 1'b0;
        set_err   = 1'b0;
        case (state)
            COLLECT: begin
                if (accept) begin
                    if (is_cell) begin
                        if (col == COL_FULL) begin
                            state_nxt = ERROR;
                            set_err   = 1'b1;
                        end else begin
                            set_tree = is_tree;
                            set_yard = is_yard;
                            col_nxt  = col + CW'(1);
                            if ((row == ROW_LAST) && (col == COL_LAST)) begin
                                state_nxt = DONE;
                                set_done  = 1'b1;
                            end
                        end
                    end else if (is_cr) begin
                        state_nxt = COLLECT;
                    end else if (is_lf && (col == COL_FULL)) begin
                        row_nxt = row + RW'(1);
                        col_nxt = '0;
                    end else begin
                        state_nxt = ERROR;
                        set_err   = 1'b1;
                    end
                end
            end
            DONE:    state_nxt = DONE;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT;
            row         <= '0;
            col         <= '0;
            trees       <= '0;
            lumberyards <= '0;
            load        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else if (clear) begin
            state       <= COLLECT;
            row         <= '0;
            col         <= '0;
            trees       <= '0;
            lumberyards <= '0;
            load        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
            col   <= col_nxt;
            load  <= set_done;
            if (set_done)
                done <= 1'b1;
            if (set_err)
                error <= 1'b1;
            if (set_tree)
                trees[cell_idx] <= 1'b1;
            if (set_yard)
                lumberyards[cell_idx] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_field_loader.sv
// Directed bench for field_loader: a 4x3 instance for the scenario table and a
// default 50x50 instance fed one random full-size map.
module tb_field_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [11:0] trees, lumberyards;
    logic        load, done, error;

    logic          b_clear;
    logic          b_valid;
    logic [7:0]    b_data;
    logic          b_ready;
    logic [2499:0] b_trees, b_yards;
    logic          b_load, b_done, b_error;

    int n_vec = 0;
    int n_err = 0;
    int load_cnt = 0;
    int b_load_cnt = 0;

    logic [49:0] exp_tr [50];
    logic [49:0] exp_yd [50];
    logic [7:0]  big_map [50][50];

    always #5 clk = ~clk;

    field_loader #(.WIDTH(4), .HEIGHT(3)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .trees(trees), .lumberyards(lumberyards),
        .load(load), .done(done), .error(error)
    );

    field_loader big (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_ready), .trees(b_trees), .lumberyards(b_yards),
        .load(b_load), .done(b_done), .error(b_error)
    );

    always @(negedge clk) begin
        if (load)
            load_cnt++;
        if (b_load)
            b_load_cnt++;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 ns after the edge that accepted the byte.
    task automatic send(input logic [7:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 20) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            chk_eq("ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input int maxgap);
        for (int i = 0; i < s.len(); i++)
            send(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic do_clear();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk_eq({tag, "_trees"}, 64'(trees), 64'h0);
        chk_eq({tag, "_yards"}, 64'(lumberyards), 64'h0);
        chk_eq({tag, "_load"}, 64'(load), 64'h0);
        chk_eq({tag, "_done"}, 64'(done), 64'h0);
        chk_eq({tag, "_error"}, 64'(error), 64'h0);
        chk_eq({tag, "_ready"}, 64'(in_ready), 64'h1);
    endtask

    // Feeds the reference 4x3 map; crlf selects "\r\n" line ends.
    task automatic run_map(input string tag, input int maxgap, input bit crlf);
        load_cnt = 0;
        if (crlf)
            send_str(".|#.\r\n#..|\r\n||#", maxgap);
        else
            send_str(".|#.\n#..|\n||#", maxgap);
        chk_eq({tag, "_preload"}, 64'(load), 64'h0);
        chk_eq({tag, "_predone"}, 64'(done), 64'h0);
        send(8'h23, maxgap);
        chk_eq({tag, "_load"}, 64'(load), 64'h1);
        chk_eq({tag, "_done"}, 64'(done), 64'h1);
        chk_eq({tag, "_trees"}, 64'(trees), 64'h382);
        chk_eq({tag, "_yards"}, 64'(lumberyards), 64'hC14);
        tick();
        chk_eq({tag, "_loadfall"}, 64'(load), 64'h0);
        if (crlf)
            send(8'h0D, maxgap);
        send(8'h0A, maxgap);
        send(8'h7C, maxgap);
        chk_eq({tag, "_hold_trees"}, 64'(trees), 64'h382);
        chk_eq({tag, "_hold_yards"}, 64'(lumberyards), 64'hC14);
        chk_eq({tag, "_hold_done"}, 64'(done), 64'h1);
        chk_eq({tag, "_hold_ready"}, 64'(in_ready), 64'h1);
        tick();
        chk_eq({tag, "_loadcnt"}, 64'(load_cnt), 64'h1);
    endtask

    task automatic send_big(input logic [7:0] b);
        int t;
        b_valid = 1'b1;
        b_data  = b;
        t = 0;
        while (!b_ready && t < 20) begin
            tick();
            t++;
        end
        if (!b_ready) begin
            chk_eq("big_ready_timeout", 64'(b_ready), 64'd1);
            b_valid = 1'b0;
            return;
        end
        tick();
        b_valid = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        b_clear = 1'b0; b_valid = 1'b0; b_data = 8'h00;
        repeat (3) tick();
        chk_idle("rst_hold");
        rst_n = 1'b1;
        tick();
        chk_idle("rst");

        run_map("clean", 0, 1'b0);

        do_clear();
        chk_idle("clr1");
        run_map("crlf", 3, 1'b1);

        do_clear();
        load_cnt = 0;
        send_str(".|", 0);
        chk_eq("bad_pre_err", 64'(error), 64'h0);
        send(8'h58, 0);
        chk_eq("bad_err", 64'(error), 64'h1);
        chk_eq("bad_ready", 64'(in_ready), 64'h0);
        chk_eq("bad_trees", 64'(trees), 64'h002);
        repeat (4) tick();
        chk_eq("bad_hold_trees", 64'(trees), 64'h002);
        chk_eq("bad_loadcnt", 64'(load_cnt), 64'h0);
        do_clear();
        chk_idle("bad_clr");
        run_map("after_bad", 0, 1'b0);

        // Byte presented in the clear cycle must be dropped.
        tick();
        clear = 1'b1; in_valid = 1'b1; in_data = 8'h7C;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk_eq("clrdrop_trees", 64'(trees), 64'h0);
        send(8'h7C, 0);
        chk_eq("clrdrop_col0", 64'(trees), 64'h001);

        do_clear();
        send_str(".|", 0);
        chk_eq("early_pre", 64'(error), 64'h0);
        send(8'h0A, 0);
        chk_eq("early_err", 64'(error), 64'h1);
        chk_eq("early_ready", 64'(in_ready), 64'h0);

        do_clear();
        send_str(".|#.", 0);
        chk_eq("long_pre", 64'(error), 64'h0);
        send(8'h2E, 0);
        chk_eq("long_err", 64'(error), 64'h1);
        chk_eq("long_trees", 64'(trees), 64'h002);
        chk_eq("long_yards", 64'(lumberyards), 64'h004);

        do_clear();
        send_str(".|#.\n#..|\n", 0);
        chk_eq("mid_trees", 64'(trees), 64'h082);
        chk_eq("mid_yards", 64'(lumberyards), 64'h014);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("mid_rst");
        tick();
        rst_n = 1'b1;
        run_map("after_rst", 0, 1'b0);

        for (int r = 0; r < 50; r++) begin
            exp_tr[r] = '0;
            exp_yd[r] = '0;
            for (int c = 0; c < 50; c++) begin
                case ($urandom_range(0, 2))
                    0: big_map[r][c] = 8'h2E;
                    1: begin big_map[r][c] = 8'h7C; exp_tr[r][c] = 1'b1; end
                    default: begin big_map[r][c] = 8'h23; exp_yd[r][c] = 1'b1; end
                endcase
            end
        end
        b_load_cnt = 0;
        for (int r = 0; r < 50; r++) begin
            for (int c = 0; c < 50; c++)
                send_big(big_map[r][c]);
            if (r == 49) begin
                chk_eq("big_load", 64'(b_load), 64'h1);
                chk_eq("big_done", 64'(b_done), 64'h1);
            end
            send_big(8'h0A);
        end
        repeat (3) tick();
        chk_eq("big_loadcnt", 64'(b_load_cnt), 64'h1);
        chk_eq("big_error", 64'(b_error), 64'h0);
        for (int r = 0; r < 50; r++) begin
            chk_eq($sformatf("big_tr_row%0d", r), 64'(b_trees[r*50 +: 50]), 64'(exp_tr[r]));
            chk_eq($sformatf("big_yd_row%0d", r), 64'(b_yards[r*50 +: 50]), 64'(exp_yd[r]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
